fpga_robots_game_kc_tx: RTL and testbench

Serial-port keycode transmitter: the host-facing counterpart of the serial keycode decoder in the game control logic. It accepts 8-bit keycodes and buffers them in a small FIFO. Each keycode goes out over the serial TX strobe/ready interface as the two-byte nibble protocol: `0x40|hi` loads the receiver's nibble buffer, then `0x50|lo` completes the code. It sits between game logic (for example, echoing PS/2 keycodes to the host) and the serial transmitter.

---
 rtl/fpga_robots_game_kc_tx_pkg.sv | 17 +
 rtl/fpga_robots_game_kc_fifo.sv | 52 +++++
 rtl/fpga_robots_game_kc_tx.sv | 123 ++++++++++++
 tb/tb_fpga_robots_game_kc_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_robots_game_kc_tx_pkg.sv
// Shared constants for the serial keycode transmitter: byte prefixes and FSM encodings.
package fpga_robots_game_kc_tx_pkg;

  localparam logic [3:0] HiPrefix = 4'h4;
  localparam logic [3:0] LoPrefix = 4'h5;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHi    = 3'd1;
  localparam logic [2:0] StGapHi = 3'd2;
  localparam logic [2:0] StLo    = 3'd3;
  localparam logic [2:0] StGapLo = 3'd4;

  function automatic logic [7:0] kc_byte(input logic [3:0] prefix, input logic [3:0] nib);
    return {prefix, nib};
  endfunction

endpackage

// File: rtl/fpga_robots_game_kc_fifo.sv
// Count-based synchronous FIFO with asynchronous active-high reset.
module fpga_robots_game_kc_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

  logic [WIDTH-1:0]      mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpga_robots_game_kc_tx.sv
// Keycode transmitter: FIFO-buffered codes sent as 0x40|hi then 0x50|lo serial bytes.
// Define FPGA_ROBOTS_KC_TX_ELIDE_HI_EN to skip a high byte matching the last one sent.
module fpga_robots_game_kc_tx
  import fpga_robots_game_kc_tx_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kc_dat,
  input  logic       kc_stb,
  output logic       kc_full,
  output logic       kc_ovf,
  output logic       busy,
  output logic [7:0] ser_tx_dat,
  output logic       ser_tx_stb,
  input  logic       ser_tx_rdy
);

  logic [2:0] state_q, state_d;
  logic [7:0] cur_q, cur_d;
  logic [7:0] dat_q, dat_d;
  logic       stb_q, stb_d;
  logic       ovf_q;
  logic       pop;
  logic [7:0] head;
  logic       empty;
`ifdef FPGA_ROBOTS_KC_TX_ELIDE_HI_EN
  logic [3:0] last_hi_q, last_hi_d;
  logic       hi_valid_q, hi_valid_d;
`endif

  fpga_robots_game_kc_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (kc_stb),
    .push_dat(kc_dat),
    .pop     (pop),
    .head    (head),
    .full    (kc_full),
    .empty   (empty)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dat_d   = dat_q;
    stb_d   = 1'b0;
    pop     = 1'b0;
`ifdef FPGA_ROBOTS_KC_TX_ELIDE_HI_EN
    last_hi_d  = last_hi_q;
    hi_valid_d = hi_valid_q;
`endif
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop   = 1'b1;
          cur_d = head;
`ifdef FPGA_ROBOTS_KC_TX_ELIDE_HI_EN
          // Receiver still holds the previous high nibble, so it need not be resent.
          state_d = (hi_valid_q && (head[7:4] == last_hi_q)) ? StLo : StHi;
`else
          state_d = StHi;
`endif
        end
      end
      StHi: begin
        if (ser_tx_rdy) begin
          stb_d   = 1'b1;
          dat_d   = kc_byte(HiPrefix, cur_q[7:4]);
          state_d = StGapHi;
`ifdef FPGA_ROBOTS_KC_TX_ELIDE_HI_EN
          last_hi_d  = cur_q[7:4];
          hi_valid_d = 1'b1;
`endif
        end
      end
      StGapHi: state_d = StLo;
      StLo: begin
        if (ser_tx_rdy) begin
          stb_d   = 1'b1;
          dat_d   = kc_byte(LoPrefix, cur_q[3:0]);
          state_d = StGapLo;
        end
      end
      StGapLo: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      dat_q   <= '0;
      stb_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef FPGA_ROBOTS_KC_TX_ELIDE_HI_EN
      last_hi_q  <= '0;
      hi_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
      ovf_q   <= kc_stb && kc_full;
`ifdef FPGA_ROBOTS_KC_TX_ELIDE_HI_EN
      last_hi_q  <= last_hi_d;
      hi_valid_q <= hi_valid_d;
`endif
    end
  end

  assign ser_tx_dat = dat_q;
  assign ser_tx_stb = stb_q;
  assign kc_ovf     = ovf_q;
  assign busy       = !empty || (state_q != StIdle);

endmodule

// File: tb/tb_fpga_robots_game_kc_tx.sv
// Self-checking bench for fpga_robots_game_kc_tx: timeline reference model plus directed cases.
module tb_fpga_robots_game_kc_tx;

  localparam int Depth = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kc_dat = '0;
  logic       kc_stb = 1'b0;
  logic       kc_full, kc_ovf, busy, ser_tx_stb;
  logic [7:0] ser_tx_dat;
  logic       ser_tx_rdy = 1'b0;

  fpga_robots_game_kc_tx #(.DEPTH_LOG2(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .kc_dat    (kc_dat),
    .kc_stb    (kc_stb),
    .kc_full   (kc_full),
    .kc_ovf    (kc_ovf),
    .busy      (busy),
    .ser_tx_dat(ser_tx_dat),
    .ser_tx_stb(ser_tx_stb),
    .ser_tx_rdy(ser_tx_rdy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted codes and a per-code byte schedule in absolute cycles.
  logic [7:0] mq[$];
  logic [7:0] pend[$];
  int         cyc = 0;
  bit         active;
  int         elig_at, done_at;
  bit         m_hv;
  logic [3:0] m_lh;
  logic [7:0] code;
  bit         full_c;
  logic       e_stb, e_ovf;
  logic [7:0] e_dat;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        pend.delete();
        active = 0;
        m_hv   = 0;
        m_lh   = '0;
        e_stb  = 0;
        e_ovf  = 0;
        e_dat  = '0;
      end else begin
        e_stb  = 0;
        e_ovf  = 0;
        full_c = (mq.size() == Depth);
        if (!active) begin
          if (mq.size() > 0) begin
            code    = mq.pop_front();
            active  = 1;
            elig_at = cyc + 1;
            pend.delete();
`ifdef FPGA_ROBOTS_KC_TX_ELIDE_HI_EN
            if (!(m_hv && code[7:4] == m_lh)) pend.push_back({4'h4, code[7:4]});
`else
            pend.push_back({4'h4, code[7:4]});
`endif
            pend.push_back({4'h5, code[3:0]});
            m_hv = 1;
            m_lh = code[7:4];
          end
        end else if (pend.size() > 0) begin
          if (cyc >= elig_at && ser_tx_rdy) begin
            e_stb   = 1;
            e_dat   = pend.pop_front();
            elig_at = cyc + 2;
            if (pend.size() == 0) done_at = cyc + 2;
          end
        end else if (cyc + 1 >= done_at) begin
          active = 0;
        end
        if (kc_stb) begin
          if (full_c) e_ovf = 1;
          else mq.push_back(kc_dat);
        end
        cyc++;
      end
    end
  end

  // Per-cycle compare and strobe capture, half a cycle after the active edge.
  logic [7:0] cap_dat[$];
  int         cap_cyc[$];
  int         ovf_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("stb", ser_tx_stb, e_stb);
        chk("dat", ser_tx_dat, e_dat);
        chk("full", kc_full, (mq.size() == Depth));
        chk("ovf", kc_ovf, e_ovf);
        chk("busy", busy, (mq.size() > 0) || active);
        if (ser_tx_stb) begin
          cap_dat.push_back(ser_tx_dat);
          cap_cyc.push_back(cyc);
        end
        if (kc_ovf) ovf_cnt++;
      end
    end
  end

  logic [7:0] expq[$];

  function automatic logic [7:0] cap_at(input int i);
    return (i < cap_dat.size()) ? cap_dat[i] : 8'hxx;
  endfunction

  task automatic check_cap(input string name);
    chk({name, "_len"}, cap_dat.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) chk(name, cap_at(i), expq[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    kc_stb = 1'b1;
    kc_dat = d;
    tick();
    kc_stb = 1'b0;
  endtask

  int pc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stb", ser_tx_stb, 0);
    chk("rst_dat", ser_tx_dat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", kc_full, 0);
    rst = 1'b0;
    tick();

    // Single code timing.
    ser_tx_rdy = 1'b1;
    cap_dat.delete(); cap_cyc.delete();
    pc = cyc;
    push(8'hE0);
    repeat (8) tick();
    chk("single_len", cap_dat.size(), 2);
    chk("single_hi", cap_at(0), 8'h4E);
    chk("single_lo", cap_at(1), 8'h50);
    if (cap_cyc.size() == 2) begin
      chk("single_hi_cyc", cap_cyc[0] - pc, 3);
      chk("single_lo_cyc", cap_cyc[1] - pc, 5);
    end
    chk("single_idle", busy, 0);

    // Stalled transmitter.
    ser_tx_rdy = 1'b0;
    cap_dat.delete(); cap_cyc.delete();
    push(8'h75);
    repeat (20) tick();
    chk("stall_none", cap_dat.size(), 0);
    ser_tx_rdy = 1'b1;
    repeat (8) tick();
    expq = '{8'h47, 8'h55};
    check_cap("stall");
    if (cap_cyc.size() == 2) chk("stall_gap", cap_cyc[1] - cap_cyc[0], 2);

    // Overflow: one code sits in the engine, eight fill the FIFO, the tenth is dropped.
    ser_tx_rdy = 1'b0;
    cap_dat.delete(); cap_cyc.delete();
    ovf_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      push(8'(i));
      if (i == 8) chk("ovf_notfull", kc_full, 0);
      if (i == 9) chk("ovf_full", kc_full, 1);
    end
    chk("ovf_pulse", kc_ovf, 1);
    ser_tx_rdy = 1'b1;
    repeat (60) tick();
    chk("ovf_cnt", ovf_cnt, 1);
    expq.delete();
    for (int i = 1; i <= 9; i++) begin
      expq.push_back(8'h40);
      expq.push_back(8'h50 | 8'(i));
    end
    check_cap("ovf_seq");

    // High-byte elision.
    cap_dat.delete(); cap_cyc.delete();
    push(8'h1C);
    push(8'h1B);
    push(8'h2B);
    repeat (25) tick();
`ifdef FPGA_ROBOTS_KC_TX_ELIDE_HI_EN
    expq = '{8'h41, 8'h5C, 8'h5B, 8'h42, 8'h5B};
`else
    expq = '{8'h41, 8'h5C, 8'h41, 8'h5B, 8'h42, 8'h5B};
`endif
    check_cap("elide");

    // Push at full while the engine pops.
    ser_tx_rdy = 1'b0;
    for (int i = 0; i < 9; i++) push(8'h60 + 8'(i));
    chk("popfull_full", kc_full, 1);
    ser_tx_rdy = 1'b1;
    ovf_cnt = 0;
    for (int i = 0; i < 30; i++) push(8'h70 + 8'(i));
    repeat (60) tick();
    chk("popfull_ovf", (ovf_cnt > 0), 1);

    // Asynchronous reset between high and low bytes.
    cap_dat.delete(); cap_cyc.delete();
    pc = cyc;
    push(8'h1A);
    push(8'h33);
    push(8'h44);
    tick();
    #3 rst = 1'b1;
    #1;
    chk("arst_stb", ser_tx_stb, 0);
    chk("arst_dat", ser_tx_dat, 0);
    chk("arst_busy", busy, 0);
    chk("arst_full", kc_full, 0);
    chk("arst_ovf", kc_ovf, 0);
    tick();
    #2 rst = 1'b0;
    expq = '{8'h41};
    check_cap("arst_before");
    cap_dat.delete(); cap_cyc.delete();
    push(8'h1D);
    repeat (10) tick();
    expq = '{8'h41, 8'h5D};
    check_cap("arst_after");

    // Randomized traffic with a limited set of high nibbles to exercise elision.
    for (int i = 0; i < 4000; i++) begin
      kc_stb     = ($urandom_range(0, 99) < 30);
      kc_dat     = {($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(1, 2)),
                    4'($urandom)};
      ser_tx_rdy = ($urandom_range(0, 99) < 70);
      tick();
    end
    kc_stb     = 1'b0;
    ser_tx_rdy = 1'b1;
    repeat (80) tick();
    chk("drain_idle", busy, 0);
    chk("drain_model", (mq.size() == 0) && !active, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
